// File: rtl/fdc_host_if.sv
// ============================================================================
//  Module   : fdc_host_if
//  Purpose  : CPU-bus glue for a WD93-compatible FDC core: system port #FF,
//             controller reset stretcher, drive select, motor hold, status sync.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fdc_host_if #(
    parameter int NUM_DRIVES  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_PULSE = 16,
    parameter int MOTOR_HOLD  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           a,
    input  logic [7:0]            d,
    input  logic                  wr_n,
    input  logic                  rd_n,
    input  logic                  iorq_n,
    input  logic                  cs_n,
    input  logic                  csff_n,
    output logic [7:0]            dout,
    output logic                  oe_n,
    input  logic [7:0]            ctl_do,
    input  logic                  ctl_drq,
    input  logic                  ctl_intrq,
    input  logic                  ctl_hld,
    output logic                  ctl_wr_en,
    output logic                  ctl_reset_n,
    output logic                  ctl_hrdy,
    output logic                  drq_r_dreg,
    output logic                  irq_r_sreg,
    output logic                  fdc_side1,
    output logic [NUM_DRIVES-1:0] fdc_ds,
    output logic                  fdc_motor
);

    localparam int c_RST_W = $clog2(RESET_PULSE + 1);

    logic [4:0]             r_ff;
    logic [c_RST_W-1:0]     r_rst_cnt;
    logic                   r_ctl_reset_n;
    logic [SYNC_STAGES-1:0] r_drq_sync;
    logic [SYNC_STAGES-1:0] r_intrq_sync;
    logic [SYNC_STAGES-1:0] r_hld_sync;
    logic                   r_irq_r_sreg;
    logic                   r_drq_r_dreg;

    logic w_ior;
    logic w_ff_wr;
    logic w_drq_s;
    logic w_intrq_s;
    logic w_hld_s;
    logic w_sreg_rd;
    logic w_dreg_acc;
    logic w_motor;
    logic w_unused_bits;

    assign w_ior         = iorq_n | rd_n;
    assign w_ff_wr       = ~csff_n & ~wr_n & ~iorq_n;
    assign w_drq_s       = r_drq_sync[SYNC_STAGES-1];
    assign w_intrq_s     = r_intrq_sync[SYNC_STAGES-1];
    assign w_hld_s       = r_hld_sync[SYNC_STAGES-1];
    assign w_sreg_rd     = ~w_ior & ~cs_n & (a[6:5] == 2'b00);
    assign w_dreg_acc    = ~iorq_n & ~(wr_n & rd_n) & ~cs_n & (a[6:5] == 2'b11);
    assign w_unused_bits = ^{a[15:7], a[4:0], d[7:5]};

    // Only a falling ff[2] restarts the pulse; raising it mid-count just waits out the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ff          <= '0;
            r_rst_cnt     <= c_RST_W'(RESET_PULSE);
            r_ctl_reset_n <= 1'b0;
        end else begin
            if (w_ff_wr) begin
                r_ff <= d[4:0];
            end
            if (w_ff_wr && r_ff[2] && !d[2]) begin
                r_rst_cnt <= c_RST_W'(RESET_PULSE);
            end else if (r_rst_cnt != '0) begin
                r_rst_cnt <= r_rst_cnt - c_RST_W'(1);
            end
            r_ctl_reset_n <= r_ff[2] & (r_rst_cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drq_sync   <= '0;
            r_intrq_sync <= '0;
            r_hld_sync   <= '0;
        end else begin
            r_drq_sync   <= {r_drq_sync[SYNC_STAGES-2:0], ctl_drq};
            r_intrq_sync <= {r_intrq_sync[SYNC_STAGES-2:0], ctl_intrq};
            r_hld_sync   <= {r_hld_sync[SYNC_STAGES-2:0], ctl_hld};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !r_ctl_reset_n) begin
            r_irq_r_sreg <= 1'b0;
            r_drq_r_dreg <= 1'b0;
        end else begin
            r_irq_r_sreg <= r_irq_r_sreg ? w_intrq_s : w_sreg_rd;
            r_drq_r_dreg <= r_drq_r_dreg ? w_drq_s : w_dreg_acc;
        end
    end

    generate
        if (MOTOR_HOLD > 0) begin : g_hold
            localparam int c_HOLD_W = $clog2(MOTOR_HOLD + 1);
            logic [c_HOLD_W-1:0] r_hold_cnt;
            logic                w_hld_fall;

            // Load on the edge where hld_s drops so the motor never blinks off.
            assign w_hld_fall = w_hld_s & ~r_hld_sync[SYNC_STAGES-2];

            always_ff @(posedge clk) begin
                if (reset || !r_ctl_reset_n) begin
                    r_hold_cnt <= '0;
                end else if (w_hld_fall) begin
                    r_hold_cnt <= c_HOLD_W'(MOTOR_HOLD);
                end else if (w_hld_s) begin
                    r_hold_cnt <= '0;
                end else if (r_hold_cnt != '0) begin
                    r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
                end
            end

            assign w_motor = w_hld_s | (r_hold_cnt != '0);
        end else begin : g_no_hold
            assign w_motor = w_hld_s;
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < NUM_DRIVES; i++) begin : g_ds
            assign fdc_ds[i] = w_motor & (r_ff[1:0] == 2'(i));
        end
    endgenerate

    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (!w_ior) begin
            if (!csff_n) begin
                dout = {w_intrq_s, w_drq_s, 6'h3F};
                oe_n = 1'b0;
            end else if (!cs_n) begin
                dout = ctl_do;
                oe_n = 1'b0;
            end
        end
    end

    assign ctl_wr_en   = ~(cs_n | wr_n);
    assign ctl_reset_n = r_ctl_reset_n;
    assign ctl_hrdy    = r_ff[3];
    assign fdc_side1   = ~r_ff[4];
    assign fdc_motor   = w_motor;
    assign irq_r_sreg  = r_irq_r_sreg;
    assign drq_r_dreg  = r_drq_r_dreg;

endmodule

`default_nettype wire

// File: tb/tb_fdc_host_if.sv
// ============================================================================
//  Module   : tb_fdc_host_if
//  Purpose  : Directed bench for fdc_host_if with a cycle-tagged scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fdc_host_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [7:0]  d;
    logic        wr_n, rd_n, iorq_n, cs_n, csff_n;
    logic [7:0]  ctl_do;
    logic        ctl_drq, ctl_intrq, ctl_hld;

    logic [7:0]  dout, dout2;
    logic        oe_n, oe_n2;
    logic        ctl_wr_en, ctl_reset_n, ctl_hrdy, drq_r_dreg, irq_r_sreg;
    logic        fdc_side1, fdc_motor;
    logic [3:0]  fdc_ds;
    logic        ctl_wr_en2, ctl_reset_n2, ctl_hrdy2, drq_r_dreg2, irq_r_sreg2;
    logic        fdc_side1_2, fdc_motor2;
    logic [1:0]  fdc_ds2;

    always #5 clk = ~clk;

    fdc_host_if #(.NUM_DRIVES(4), .SYNC_STAGES(2), .RESET_PULSE(16), .MOTOR_HOLD(100)) dut (
        .clk(clk), .reset(reset), .a(a), .d(d), .wr_n(wr_n), .rd_n(rd_n), .iorq_n(iorq_n),
        .cs_n(cs_n), .csff_n(csff_n), .dout(dout), .oe_n(oe_n), .ctl_do(ctl_do),
        .ctl_drq(ctl_drq), .ctl_intrq(ctl_intrq), .ctl_hld(ctl_hld), .ctl_wr_en(ctl_wr_en),
        .ctl_reset_n(ctl_reset_n), .ctl_hrdy(ctl_hrdy), .drq_r_dreg(drq_r_dreg),
        .irq_r_sreg(irq_r_sreg), .fdc_side1(fdc_side1), .fdc_ds(fdc_ds), .fdc_motor(fdc_motor)
    );

    fdc_host_if #(.NUM_DRIVES(2), .SYNC_STAGES(2), .RESET_PULSE(16), .MOTOR_HOLD(0)) dut2 (
        .clk(clk), .reset(reset), .a(a), .d(d), .wr_n(wr_n), .rd_n(rd_n), .iorq_n(iorq_n),
        .cs_n(cs_n), .csff_n(csff_n), .dout(dout2), .oe_n(oe_n2), .ctl_do(ctl_do),
        .ctl_drq(ctl_drq), .ctl_intrq(ctl_intrq), .ctl_hld(ctl_hld), .ctl_wr_en(ctl_wr_en2),
        .ctl_reset_n(ctl_reset_n2), .ctl_hrdy(ctl_hrdy2), .drq_r_dreg(drq_r_dreg2),
        .irq_r_sreg(irq_r_sreg2), .fdc_side1(fdc_side1_2), .fdc_ds(fdc_ds2), .fdc_motor(fdc_motor2)
    );

    localparam int c_RSTN = 0, c_HRDY = 1, c_SIDE = 2, c_DS = 3, c_MOT = 4, c_IRQ = 5,
                   c_DRQ = 6, c_DOUT = 7, c_OEN = 8, c_WREN = 9, c_DS2 = 10, c_MOT2 = 11;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   r_drain = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            c_RSTN:  return {7'd0, ctl_reset_n};
            c_HRDY:  return {7'd0, ctl_hrdy};
            c_SIDE:  return {7'd0, fdc_side1};
            c_DS:    return {4'd0, fdc_ds};
            c_MOT:   return {7'd0, fdc_motor};
            c_IRQ:   return {7'd0, irq_r_sreg};
            c_DRQ:   return {7'd0, drq_r_dreg};
            c_DOUT:  return dout;
            c_OEN:   return {7'd0, oe_n};
            c_WREN:  return {7'd0, ctl_wr_en};
            c_DS2:   return {6'd0, fdc_ds2};
            default: return {7'd0, fdc_motor2};
        endcase
    endfunction

    // Monitor: compares every scoreboard entry due in the current cycle.
    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc || r_drain) begin
                checks++;
                if (r_drain) begin
                    errors++;
                    $display("FAIL %s: never sampled (due cyc %0d, now %0d)", sb[k].name, sb[k].cyc, cyc);
                end else if (actual(sb[k].sel) !== sb[k].exp) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h", sb[k].name, cyc,
                             actual(sb[k].sel), sb[k].exp);
                end
                sb.delete(k);
            end
        end
    end

    task automatic expect_at(input int dly, input int sel, input logic [7:0] exp, input string name);
        chk_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        wr_n = 1'b1; rd_n = 1'b1; iorq_n = 1'b1; cs_n = 1'b1; csff_n = 1'b1;
    endtask

    task automatic wr_ff(input logic [7:0] val);
        d = val; csff_n = 1'b0; wr_n = 1'b0; iorq_n = 1'b0;
        tick(1);
        bus_idle();
    endtask

    task automatic io_rd(input logic [15:0] addr);
        a = addr; cs_n = 1'b0; rd_n = 1'b0; iorq_n = 1'b0;
    endtask

    initial begin
        reset = 1'b1; a = 16'h0; d = 8'h0; ctl_do = 8'hA5;
        ctl_drq = 1'b0; ctl_intrq = 1'b0; ctl_hld = 1'b0;
        bus_idle();
        tick(3);
        expect_at(0, c_RSTN, 8'h00, "rst_ctl_reset_n");
        expect_at(0, c_HRDY, 8'h00, "rst_hrdy");
        expect_at(0, c_SIDE, 8'h01, "rst_side1");
        expect_at(0, c_DS,   8'h00, "rst_ds");
        expect_at(0, c_MOT,  8'h00, "rst_motor");
        expect_at(0, c_IRQ,  8'h00, "rst_irq");
        expect_at(0, c_DRQ,  8'h00, "rst_drq");
        expect_at(0, c_DOUT, 8'hFF, "rst_dout");
        expect_at(0, c_OEN,  8'h01, "rst_oe_n");
        tick(1);
        reset = 1'b0;

        // Reset stretcher after power-on: low through edge +15, high at +16.
        wr_ff(8'h0C);
        expect_at(0,  c_HRDY, 8'h01, "ff0c_hrdy");
        expect_at(0,  c_SIDE, 8'h01, "ff0c_side1");
        expect_at(0,  c_DS,   8'h00, "ff0c_ds_motor_off");
        expect_at(15, c_RSTN, 8'h00, "por_pulse_low");
        expect_at(16, c_RSTN, 8'h01, "por_pulse_high");
        cs_n = 1'b0; wr_n = 1'b0;
        expect_at(0, c_WREN, 8'h01, "wr_en_on");
        tick(1);
        bus_idle();
        expect_at(0, c_WREN, 8'h00, "wr_en_off");
        tick(20);

        // Register-read flags and synchronised status.
        ctl_intrq = 1'b1; ctl_drq = 1'b1;
        tick(3);
        io_rd(16'h0000);
        expect_at(0, c_DOUT, 8'hA5, "cs_read_dout");
        expect_at(0, c_OEN,  8'h00, "cs_read_oe_n");
        tick(1);
        bus_idle();
        expect_at(0, c_IRQ, 8'h01, "irq_set");
        io_rd(16'h0060);
        tick(1);
        bus_idle();
        expect_at(0, c_DRQ, 8'h01, "drq_set");
        ctl_intrq = 1'b0;
        expect_at(2, c_IRQ, 8'h01, "irq_hold_sync");
        expect_at(3, c_IRQ, 8'h00, "irq_clear");
        tick(4);
        io_rd(16'h0020);
        csff_n = 1'b0;
        expect_at(0, c_DOUT, 8'h7F, "ff_read_dout");
        expect_at(0, c_OEN,  8'h00, "ff_read_oe_n");
        tick(1);
        bus_idle();
        ctl_drq = 1'b0;
        expect_at(3, c_DRQ, 8'h00, "drq_clear");
        tick(5);

        // Controller reset via ff[2]: 1->0 then 0->1 three cycles later.
        ctl_intrq = 1'b1; ctl_drq = 1'b1;
        tick(3);
        io_rd(16'h0000); tick(1); bus_idle();
        io_rd(16'h0060); tick(1); bus_idle();
        wr_ff(8'h08);
        expect_at(0, c_RSTN, 8'h01, "ff2_pulse_prev");
        expect_at(1, c_RSTN, 8'h00, "ff2_pulse_start");
        expect_at(2, c_IRQ,  8'h00, "ff2_irq_cleared");
        expect_at(2, c_DRQ,  8'h00, "ff2_drq_cleared");
        tick(2);
        wr_ff(8'h0C);
        expect_at(13, c_RSTN, 8'h00, "ff2_pulse_last_low");
        expect_at(14, c_RSTN, 8'h01, "ff2_pulse_end");
        ctl_intrq = 1'b0; ctl_drq = 1'b0;
        tick(20);

        // Motor hold, drive 2.
        wr_ff(8'h0E);
        ctl_hld = 1'b1;
        expect_at(1, c_MOT,  8'h00, "mot_sync_lag");
        expect_at(2, c_MOT,  8'h01, "mot_on");
        expect_at(2, c_DS,   8'h04, "ds_drive2");
        expect_at(2, c_MOT2, 8'h01, "mot2_on");
        tick(5);
        ctl_hld = 1'b0;
        expect_at(1,   c_MOT2, 8'h01, "mot2_lag");
        expect_at(2,   c_MOT2, 8'h00, "mot2_off_no_hold");
        expect_at(2,   c_MOT,  8'h01, "mot_hold_start");
        expect_at(101, c_MOT,  8'h01, "mot_hold_last");
        expect_at(101, c_DS,   8'h04, "ds_hold_last");
        expect_at(102, c_MOT,  8'h00, "mot_hold_end");
        expect_at(102, c_DS,   8'h00, "ds_off");
        tick(110);

        // Re-assert hld 50 cycles into the hold window.
        ctl_hld = 1'b1;
        tick(5);
        ctl_hld = 1'b0;
        tick(52);
        ctl_hld = 1'b1;
        for (int k = 0; k < 4; k++) expect_at(k, c_MOT, 8'h01, "mot_reassert");
        expect_at(60, c_MOT, 8'h01, "mot_stays_on");
        tick(70);
        wr_ff(8'h0D);
        expect_at(0, c_DS,  8'h02, "ds_drive1");
        expect_at(0, c_DS2, 8'h02, "ds2_drive1");
        wr_ff(8'h0F);
        expect_at(0, c_DS,   8'h08, "ds_drive3");
        expect_at(0, c_DS2,  8'h00, "ds2_code3_none");
        expect_at(0, c_MOT2, 8'h01, "mot2_on_code3");
        ctl_hld = 1'b0;
        expect_at(101, c_MOT, 8'h01, "mot_hold2_last");
        expect_at(102, c_MOT, 8'h00, "mot_hold2_end");

        for (int k = 0; k < 300 && sb.size() > 0; k++) tick(1);
        r_drain = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
